// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings,
// owner identifiers and default geometry of the burst interface.
// Optional round-robin tie-break is selected by MEM_ARB_RR_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_BURST  = 4;
    localparam int DEF_BEAT_W = $clog2(DEF_BURST);

    // The requester that is not 'who'; used for round-robin tie-breaking.
    function automatic owner_t other_owner(input owner_t who);
        return (who == OWN_IC) ? OWN_DC : OWN_IC;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between icache and dcache requests.
// Without MEM_ARB_RR_EN a tie goes to the dcache; with MEM_ARB_RR_EN
// a tie goes to whichever requester did not win the previous grant.
import mem_arbiter_pkg::*;

module mem_arb_pick (
    input  logic   i_ic_valid,
    input  logic   i_dc_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_t i_last_owner,
`endif
    output logic   o_grant_any,
    output owner_t o_grant_owner
);

    // Pick a winner; a lone requester always wins.
    always_comb begin
        o_grant_any   = i_ic_valid | i_dc_valid;
        o_grant_owner = OWN_IC;
        if (i_dc_valid && !i_ic_valid) begin
            o_grant_owner = OWN_DC;
        end else if (i_dc_valid && i_ic_valid) begin
`ifdef MEM_ARB_RR_EN
            o_grant_owner = other_owner(i_last_owner);
`else
            o_grant_owner = OWN_DC;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the off-chip memory port between icache and dcache misses:
// arbitration in IDLE, command phase in CMD, then a fixed-length write
// (WR) or read (RD) burst. Read beats are routed back with zero latency.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of dcache priority.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int BURST  = DEF_BURST,
    localparam int BEAT_W = $clog2(BURST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    input  logic              dc_req_valid,
    input  logic              dc_req_rnw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [BEAT_W-1:0] dc_wbeat,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              mem_req_valid,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    output logic              mem_wdata_valid,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_rnw;
    logic [ADDR_W-1:0]   r_addr;
    logic [BEAT_W-1:0]   r_beat;

    logic                w_grant_any;
    owner_t              w_grant_owner;
    logic                w_idle;
    logic                w_grant;
    logic                w_rd_beat;

`ifdef MEM_ARB_RR_EN
    owner_t              r_last_owner;
`endif

    mem_arb_pick u_pick (
        .i_ic_valid    (ic_req_valid),
        .i_dc_valid    (dc_req_valid),
`ifdef MEM_ARB_RR_EN
        .i_last_owner  (r_last_owner),
`endif
        .o_grant_any   (w_grant_any),
        .o_grant_owner (w_grant_owner)
    );

    assign w_idle    = (r_state == ST_IDLE);
    assign w_grant   = w_idle & w_grant_any;
    assign w_rd_beat = (r_state == ST_RD) & mem_rdata_valid;

    // Main sequencer: latch the winning request, then run command and burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IC;
            r_rnw   <= 1'b1;
            r_addr  <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_owner;
                        r_rnw   <= (w_grant_owner == OWN_IC) ? 1'b1 : dc_req_rnw;
                        r_addr  <= (w_grant_owner == OWN_IC) ? ic_req_addr : dc_req_addr;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (mem_req_ready) begin
                        r_beat  <= '0;
                        r_state <= r_rnw ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (mem_wdata_ready) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_rdata_valid) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the most recent winner so the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWN_IC;
        end else if (w_grant) begin
            r_last_owner <= w_grant_owner;
        end
    end
`endif

    // Output decode from the registered state and latched command.
    always_comb begin
        ic_req_ready    = w_grant & (w_grant_owner == OWN_IC);
        dc_req_ready    = w_grant & (w_grant_owner == OWN_DC);
        mem_req_valid   = (r_state == ST_CMD);
        mem_req_rnw     = r_rnw;
        mem_req_addr    = r_addr;
        mem_wdata_valid = (r_state == ST_WR);
        mem_wdata       = dc_wdata;
        dc_wbeat        = r_beat;
        ic_resp_valid   = w_rd_beat & (r_owner == OWN_IC);
        dc_resp_valid   = w_rd_beat & (r_owner == OWN_DC);
        resp_data       = mem_rdata;
        resp_last       = w_rd_beat & (r_beat == LAST_BEAT);
        stall           = ~w_idle | ic_req_valid | dc_req_valid;
    end

endmodule
